mem_wb_sequencer: RTL

Controller that sequences the MEM stage and drives the enable and valid inputs of the MEM/WB pipeline register. Non-memory instructions pass straight through. Loads and stores are held in MEM while a multi-cycle data-memory handshake completes, with a bubble injected into MEM/WB each waiting cycle. The block also applies downstream writeback holds, times out hung accesses, and counts instructions committed into MEM/WB.

---
 rtl/mem_wb_sequencer.sv | 73 +++++++
 1 files changed

// File: rtl/mem_wb_sequencer.sv
// mem_wb_sequencer: holds loads/stores in MEM across the data-memory handshake, drives MEM/WB enable/valid,
// applies writeback holds, abandons hung accesses and counts commits into MEM/WB.
module mem_wb_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_MemWB,
    input  logic             rst_MemWB,
    input  logic             valid_ex,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             dmem_ack,
    input  logic             hold_wb,
    output logic             dmem_req,
    output logic             en_MemWB,
    output logic             valid_in_MemWB,
    output logic             stall_front,
    output logic             busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic             r_err;
    logic [CNT_W-1:0] r_ret;
    logic             w_memop;
    logic             w_acc;
    logic             w_last;

    assign w_memop = valid_ex & (mem_read | mem_write);
    assign w_acc   = ~rst_MemWB & (r_state == ACCESS);
    assign w_last  = r_wait == LAST;
    assign mem_err = r_err;
    assign retired = r_ret;

    // Enable stays high through reset so the MEM/WB register is cleared by it.
    always_comb begin
        dmem_req       = w_acc;
        busy           = w_acc;
        en_MemWB       = rst_MemWB | ~hold_wb;
        valid_in_MemWB = ~rst_MemWB & ~hold_wb & (w_acc ? dmem_ack : valid_ex & ~w_memop);
        stall_front    = ~rst_MemWB & (hold_wb | (w_acc ? ~dmem_ack & ~w_last : w_memop));
    end

    always_ff @(posedge clk_MemWB or posedge rst_MemWB) begin
        if (rst_MemWB) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_err   <= 1'b0;
            r_ret   <= '0;
        end else if (!hold_wb) begin
            if (valid_in_MemWB) r_ret <= r_ret + CNT_W'(1);
            if (r_state == IDLE) begin
                if (w_memop) begin
                    r_state <= ACCESS;
                    r_wait  <= '0;
                end
            end else if (dmem_ack) begin
                r_state <= IDLE;
            end else if (w_last) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
            end else begin
                r_wait <= r_wait + WW'(1);
            end
        end
    end
endmodule
